stack_sequencer: RTL

Command initiator for the 8-bit stack block: accepts stack-machine instructions over a valid/ready handshake and drives the stack's push/pop/tos/dataIn controls. It consumes the stack's registered read data and sequences multi-cycle pop-compute-push operations. It tracks stack depth, and returns results and error status to the upstream controller.

---
 rtl/stack_seq_pkg.sv | 37 +++
 rtl/stack_seq_alu.sv | 25 ++
 rtl/stack_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/stack_seq_pkg.sv
// Shared types and defaults for the stack command sequencer.
// Opcode/state encodings and error codes used by stack_sequencer and its ALU.
package stack_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_TOP  = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_AND  = 3'd6,
        OP_NOT  = 3'd7
    } opcodeT;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        ISSUE2,
        CAPTURE,
        WRITE,
        DONE,
        ERR
    } stateT;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;

    function automatic logic isBinary(opcodeT op);
        return op inside {OP_ADD, OP_SUB, OP_AND};
    endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational ALU for the stack sequencer.
// opA is the next-to-top operand, opB the old top.
module stack_seq_alu
    import stack_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (opcodeT'(op))
            OP_ADD:  y = opA + opB;
            OP_SUB:  y = opA - opB;
            OP_AND:  y = opA & opB;
            OP_NOT:  y = ~opA;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// Stack-machine instruction sequencer driving an 8-bit stack block.
// Define STACK_SEQ_GUARD_EN to enable underflow/overflow rejection.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       instrValid,
    output logic                       instrReady,
    input  logic [2:0]                 opcode,
    input  logic [DATA_W-1:0]          imm,
    output logic                       push,
    output logic                       pop,
    output logic                       tos,
    output logic [DATA_W-1:0]          stkDataOut,
    input  logic [DATA_W-1:0]          stkDataIn,
    output logic                       resValid,
    output logic [DATA_W-1:0]          result,
    output logic                       errValid,
    output logic [1:0]                 errCode,
    output logic [$clog2(DEPTH+1)-1:0] depth
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] D_MAX = CNT_W'(DEPTH);

    stateT  state, stateNext;
    opcodeT opQ, opIn;
    logic   readyQ, accept;
    logic   pushN, popN, tosN, resValidN;
    logic [DATA_W-1:0] opB, aluY, resultN, dataOutN;
    logic [CNT_W-1:0]  depthN;

    assign opIn       = opcodeT'(opcode);
    assign instrReady = readyQ;
    assign accept     = instrValid && readyQ;

    stack_seq_alu #(.DATA_W(DATA_W)) uAlu (
        .op  (opQ),
        .opA (stkDataIn),
        .opB (opB),
        .y   (aluY)
    );

`ifdef STACK_SEQ_GUARD_EN
    logic under, over, errValidN;
    logic [1:0] errCodeN;

    assign under = isBinary(opIn) ? (depth < CNT_W'(2))
                 : ((opIn inside {OP_POP, OP_TOP, OP_NOT}) && depth == '0);
    assign over  = (opIn == OP_PUSH) && (depth == D_MAX);
`endif

    always_comb begin
        stateNext = state;
        pushN     = 1'b0;
        popN      = 1'b0;
        tosN      = 1'b0;
        resValidN = 1'b0;
        resultN   = result;
        dataOutN  = stkDataOut;
`ifdef STACK_SEQ_GUARD_EN
        errValidN = 1'b0;
        errCodeN  = ERR_NONE;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef STACK_SEQ_GUARD_EN
                    if (under || over) begin
                        stateNext = ERR;
                        errValidN = 1'b1;
                        errCodeN  = under ? ERR_UNDER : ERR_OVER;
                    end else
`endif
                    begin
                        unique case (opIn)
                            OP_NOP: stateNext = IDLE;
                            OP_PUSH: begin
                                stateNext = WRITE;
                                pushN     = 1'b1;
                                dataOutN  = imm;
                                resultN   = imm;
                                resValidN = 1'b1;
                            end
                            OP_TOP: begin
                                stateNext = ISSUE1;
                                tosN      = 1'b1;
                            end
                            default: begin
                                stateNext = ISSUE1;
                                popN      = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ISSUE1: begin
                if (isBinary(opQ)) begin
                    stateNext = ISSUE2;
                    popN      = 1'b1;
                end else begin
                    stateNext = CAPTURE;
                end
            end
            ISSUE2: stateNext = CAPTURE;
            CAPTURE: begin
                resValidN = 1'b1;
                if (opQ inside {OP_POP, OP_TOP}) begin
                    stateNext = DONE;
                    resultN   = stkDataIn;
                end else begin
                    stateNext = WRITE;
                    pushN     = 1'b1;
                    dataOutN  = aluY;
                    resultN   = aluY;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Depth wraps modulo DEPTH+1; with guards on it never reaches a wrap.
    always_comb begin
        depthN = depth;
        if (pushN)
            depthN = (depth == D_MAX) ? '0 : depth + 1'b1;
        else if (popN)
            depthN = (depth == '0) ? D_MAX : depth - 1'b1;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            readyQ     <= 1'b0;
            depth      <= '0;
            push       <= 1'b0;
            pop        <= 1'b0;
            tos        <= 1'b0;
            resValid   <= 1'b0;
            result     <= '0;
            stkDataOut <= '0;
            opQ        <= OP_NOP;
            opB        <= '0;
        end else begin
            state      <= stateNext;
            readyQ     <= (stateNext == IDLE);
            depth      <= depthN;
            push       <= pushN;
            pop        <= popN;
            tos        <= tosN;
            resValid   <= resValidN;
            result     <= resultN;
            stkDataOut <= dataOutN;
            if (accept)
                opQ <= opIn;
            if (state == ISSUE2)
                opB <= stkDataIn;
        end
    end

`ifdef STACK_SEQ_GUARD_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            errValid <= 1'b0;
            errCode  <= ERR_NONE;
        end else begin
            errValid <= errValidN;
            errCode  <= errCodeN;
        end
    end
`else
    assign errValid = 1'b0;
    assign errCode  = ERR_NONE;
`endif

endmodule
